// File: rtl/falling_char_engine.sv
// falling_char_engine: object table, per-frame motion, key matching and
// scoring for the falling-character game; runs on the pixel clock.
module falling_char_engine #(
    parameter int SLOTS       = 8,
    parameter int CHAR_W      = 8,
    parameter int COL_W       = 10,
    parameter int ROW_W       = 10,
    parameter int SPEED_W     = 3,
    parameter int LOWER_BOUND = 480,
    parameter int MISS_LIMIT  = 3,
    localparam int IDX_W      = $clog2(SLOTS)
) (
    input  logic               pclk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               spawn_valid,
    output logic               spawn_ready,
    input  logic [CHAR_W-1:0]  spawn_char,
    input  logic [COL_W-1:0]   spawn_col,
    input  logic [SPEED_W-1:0] spawn_speed,
    input  logic               key_valid,
    input  logic [CHAR_W-1:0]  key_code,
    input  logic [IDX_W-1:0]   q_idx,
    output logic               q_active,
    output logic [CHAR_W-1:0]  q_char,
    output logic [COL_W-1:0]   q_col,
    output logic [ROW_W-1:0]   q_row,
    output logic [SLOTS-1:0]   active_mask,
    output logic               hit_pulse,
    output logic               wrong_pulse,
    output logic               miss_pulse,
    output logic [15:0]        score,
    output logic [7:0]         miss_count,
    output logic               gameover
);

    typedef enum logic [2:0] {
        IDLE,
        MOVE,
        HIT,
        COMMIT,
        OVER
    } state_t;

    localparam logic [ROW_W:0]   LB       = (ROW_W+1)'(LOWER_BOUND);
    localparam logic [7:0]       MISS_LIM = 8'(MISS_LIMIT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);

    state_t state, state_nxt;

    logic [SLOTS-1:0]   s_active;
    logic [CHAR_W-1:0]  s_char  [SLOTS];
    logic [COL_W-1:0]   s_col   [SLOTS];
    logic [ROW_W-1:0]   s_row   [SLOTS];
    logic [SPEED_W-1:0] s_speed [SLOTS];

    logic [IDX_W-1:0]  idx;
    logic              pend_frame;
    logic              pend_key;
    logic [CHAR_W-1:0] pend_code;
    logic [CHAR_W-1:0] hit_code;
    logic              best_valid;
    logic [IDX_W-1:0]  best_idx;
    logic [ROW_W-1:0]  best_row;

    logic              free_any;
    logic [IDX_W-1:0]  free_idx;
    logic              take_frame;
    logic              take_key;
    logic              last;
    logic              mv_miss;
    logic [ROW_W:0]    mv_sum;
    logic [7:0]        miss_cnt_nxt;
    logic              do_spawn;
    logic              hit_match;

    assign active_mask = s_active;
    assign do_spawn    = spawn_ready & spawn_valid;

    // Lowest-index free slot for the next spawn
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!s_active[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // State register
    always_ff @(posedge pclk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state, handshake and per-slot sweep decisions
    always_comb begin
        state_nxt    = state;
        spawn_ready  = 1'b0;
        take_frame   = 1'b0;
        take_key     = 1'b0;
        last         = (idx == LAST_IDX);
        mv_sum       = {1'b0, s_row[idx]} + (ROW_W+1)'(s_speed[idx]);
        mv_miss      = 1'b0;
        miss_cnt_nxt = miss_count;
        hit_match    = s_active[idx] && (s_char[idx] == hit_code) &&
                       (!best_valid || (s_row[idx] > best_row));
        unique case (state)
            IDLE: begin
                spawn_ready = !pend_frame && !pend_key &&
                              !gameover && free_any;
                if (frame_tick || pend_frame) begin
                    take_frame = 1'b1;
                    state_nxt  = MOVE;
                end else if (key_valid || pend_key) begin
                    take_key  = 1'b1;
                    state_nxt = HIT;
                end
            end
            MOVE: begin
                mv_miss = s_active[idx] && (mv_sum >= LB);
                if (mv_miss && (miss_count != 8'hFF))
                    miss_cnt_nxt = miss_count + 8'd1;
                if (last)
                    state_nxt = (miss_cnt_nxt >= MISS_LIM) ? OVER : IDLE;
            end
            HIT: begin
                if (last) state_nxt = COMMIT;
            end
            COMMIT: state_nxt = IDLE;
            OVER:   state_nxt = OVER;
            default: state_nxt = IDLE;
        endcase
    end

    // Slot table, pending events, counters, strobes and query port
    always_ff @(posedge pclk) begin
        if (reset) begin
            s_active    <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                s_char[i]  <= '0;
                s_col[i]   <= '0;
                s_row[i]   <= '0;
                s_speed[i] <= '0;
            end
            idx         <= '0;
            pend_frame  <= 1'b0;
            pend_key    <= 1'b0;
            pend_code   <= '0;
            hit_code    <= '0;
            best_valid  <= 1'b0;
            best_idx    <= '0;
            best_row    <= '0;
            hit_pulse   <= 1'b0;
            wrong_pulse <= 1'b0;
            miss_pulse  <= 1'b0;
            score       <= '0;
            miss_count  <= '0;
            gameover    <= 1'b0;
            q_active    <= 1'b0;
            q_char      <= '0;
            q_col       <= '0;
            q_row       <= '0;
        end else begin
            hit_pulse   <= 1'b0;
            wrong_pulse <= 1'b0;
            miss_pulse  <= 1'b0;

            if (take_frame)
                pend_frame <= 1'b0;
            else if (frame_tick && state != OVER)
                pend_frame <= 1'b1;

            if (take_key) begin
                pend_key <= 1'b0;
            end else if (key_valid && state != OVER) begin
                pend_key  <= 1'b1;
                pend_code <= key_code;
            end

            if (take_key) begin
                hit_code   <= key_valid ? key_code : pend_code;
                best_valid <= 1'b0;
            end

            if (do_spawn) begin
                s_active[free_idx] <= 1'b1;
                s_char[free_idx]   <= spawn_char;
                s_col[free_idx]    <= spawn_col;
                s_speed[free_idx]  <= spawn_speed;
                s_row[free_idx]    <= '0;
            end

            if (take_frame || take_key)
                idx <= '0;
            else if (state == MOVE || state == HIT)
                idx <= last ? '0 : idx + 1'b1;

            if (state == MOVE && s_active[idx]) begin
                if (mv_miss) begin
                    s_active[idx] <= 1'b0;
                    miss_pulse    <= 1'b1;
                end else begin
                    s_row[idx] <= mv_sum[ROW_W-1:0];
                end
            end
            miss_count <= miss_cnt_nxt;

            if (state == HIT && hit_match) begin
                best_valid <= 1'b1;
                best_idx   <= idx;
                best_row   <= s_row[idx];
            end

            if (state == COMMIT) begin
                if (best_valid) begin
                    s_active[best_idx] <= 1'b0;
                    hit_pulse          <= 1'b1;
                    if (score != 16'hFFFF) score <= score + 16'd1;
                end else begin
                    wrong_pulse <= 1'b1;
                end
            end

            if (state_nxt == OVER) gameover <= 1'b1;

            q_active <= s_active[q_idx];
            q_char   <= s_char[q_idx];
            q_col    <= s_col[q_idx];
            q_row    <= s_row[q_idx];
        end
    end

endmodule

// File: tb/tb_falling_char_engine.sv
// tb_falling_char_engine: directed checks of spawn, motion, hit/miss,
// game-over freeze and reset abort for falling_char_engine.
module tb_falling_char_engine;

    localparam int SLOTS = 8;

    logic       pclk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       spawn_valid = 1'b0;
    logic       spawn_ready;
    logic [7:0] spawn_char = '0;
    logic [9:0] spawn_col = '0;
    logic [2:0] spawn_speed = '0;
    logic       key_valid = 1'b0;
    logic [7:0] key_code = '0;
    logic [2:0] q_idx = '0;
    logic       q_active;
    logic [7:0] q_char;
    logic [9:0] q_col;
    logic [9:0] q_row;
    logic [7:0] active_mask;
    logic       hit_pulse;
    logic       wrong_pulse;
    logic       miss_pulse;
    logic [15:0] score;
    logic [7:0] miss_count;
    logic       gameover;

    int n_cmp = 0;
    int n_err = 0;
    int n_hit = 0;
    int n_wrong = 0;
    int n_miss = 0;

    falling_char_engine dut (
        .pclk        (pclk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .spawn_valid (spawn_valid),
        .spawn_ready (spawn_ready),
        .spawn_char  (spawn_char),
        .spawn_col   (spawn_col),
        .spawn_speed (spawn_speed),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .q_idx       (q_idx),
        .q_active    (q_active),
        .q_char      (q_char),
        .q_col       (q_col),
        .q_row       (q_row),
        .active_mask (active_mask),
        .hit_pulse   (hit_pulse),
        .wrong_pulse (wrong_pulse),
        .miss_pulse  (miss_pulse),
        .score       (score),
        .miss_count  (miss_count),
        .gameover    (gameover)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (hit_pulse)   n_hit++;
        if (wrong_pulse) n_wrong++;
        if (miss_pulse)  n_miss++;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic spawn(input logic [7:0] c,
                         input logic [9:0] col,
                         input logic [2:0] spd);
        int n = 0;
        spawn_char  = c;
        spawn_col   = col;
        spawn_speed = spd;
        spawn_valid = 1'b1;
        while (!spawn_ready && n < 32) begin
            tick();
            n++;
        end
        if (!spawn_ready) chk("spawn_timeout", 0, 1);
        tick();
        spawn_valid = 1'b0;
    endtask

    task automatic frame_step();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        repeat (SLOTS + 1) tick();
    endtask

    task automatic key_hit(input string tag,
                           input logic [7:0] c,
                           input logic exp_hit);
        key_code  = c;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (SLOTS) tick();
        chk({tag, "_early"}, {hit_pulse, wrong_pulse}, 0);
        tick();
        chk(tag, {hit_pulse, wrong_pulse}, exp_hit ? 2 : 1);
    endtask

    task automatic query(input logic [2:0] i);
        q_idx = i;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin
        int base;
        tick();
        do_reset();

        // reset state
        chk("rst_mask", active_mask, 0);
        chk("rst_score", score, 0);
        chk("rst_miss", miss_count, 0);
        chk("rst_over", gameover, 0);
        chk("rst_q", {q_active, q_char, q_col, q_row}, 0);
        chk("rst_ready", spawn_ready, 1);

        // single object falls 10 frames at speed 4
        base = n_hit + n_wrong + n_miss;
        spawn(8'h41, 10'd100, 3'd4);
        chk("spawn_mask", active_mask, 1);
        repeat (10) frame_step();
        query(3'd0);
        chk("fall_row", q_row, 40);
        chk("fall_col", q_col, 100);
        chk("fall_char", q_char, 8'h41);
        chk("fall_act", q_active, 1);
        chk("fall_mask", active_mask, 1);
        chk("fall_pulses", n_hit + n_wrong + n_miss - base, 0);

        // fill table, full blocks spawn, hit frees slot 3
        do_reset();
        for (int i = 0; i < SLOTS; i++)
            spawn(8'h61 + 8'(i), 10'(i * 10), 3'd0);
        chk("full_mask", active_mask, 8'hFF);
        spawn_valid = 1'b1;
        chk("full_ready", spawn_ready, 0);
        spawn_valid = 1'b0;
        key_hit("hit_slot3", 8'h64, 1'b1);
        chk("hit3_mask", active_mask, 8'hF7);
        chk("hit3_score", score, 1);
        spawn(8'h58, 10'd300, 3'd1);
        chk("refill_mask", active_mask, 8'hFF);
        query(3'd3);
        chk("refill_char", q_char, 8'h58);
        chk("refill_col", q_col, 300);

        // two 'B's: the lower one (larger row) is hit
        do_reset();
        spawn(8'h42, 10'd10, 3'd1);
        spawn(8'h42, 10'd20, 3'd5);
        repeat (10) frame_step();
        query(3'd0);
        chk("b0_row", q_row, 10);
        query(3'd1);
        chk("b1_row", q_row, 50);
        key_hit("hit_b", 8'h42, 1'b1);
        chk("hit_b_mask", active_mask, 1);
        chk("hit_b_score", score, 1);
        key_hit("wrong_z", 8'h5A, 1'b0);
        chk("wrong_score", score, 1);
        chk("wrong_mask", active_mask, 1);

        // speed 7 reaches 476 after 68 frames, misses on 69th
        do_reset();
        base = n_miss;
        spawn(8'h4D, 10'd50, 3'd7);
        repeat (68) frame_step();
        query(3'd0);
        chk("row_476", q_row, 476);
        chk("no_miss_yet", n_miss - base, 0);
        frame_step();
        chk("miss_pulse", n_miss - base, 1);
        chk("miss_mask", active_mask, 0);
        chk("miss_cnt", miss_count, 1);
        chk("miss_over", gameover, 0);

        // three misses in one frame end the game
        do_reset();
        spawn(8'h6D, 10'd1, 3'd7);
        spawn(8'h6D, 10'd2, 3'd7);
        spawn(8'h6D, 10'd3, 3'd7);
        spawn(8'h51, 10'd4, 3'd0);
        repeat (69) frame_step();
        chk("over_flag", gameover, 1);
        chk("over_misses", miss_count, 3);
        chk("over_mask", active_mask, 8'h08);
        spawn_valid = 1'b1;
        chk("over_ready", spawn_ready, 0);
        spawn_valid = 1'b0;
        base = n_hit + n_wrong;
        key_code  = 8'h51;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (12) tick();
        chk("over_key_mask", active_mask, 8'h08);
        chk("over_key_score", score, 0);
        chk("over_key_pulse", n_hit + n_wrong - base, 0);
        frame_step();
        frame_step();
        query(3'd3);
        chk("frozen_act", q_active, 1);
        chk("frozen_row", q_row, 0);
        chk("frozen_char", q_char, 8'h51);
        do_reset();
        chk("clr_over", gameover, 0);
        chk("clr_mask", active_mask, 0);
        chk("clr_miss", miss_count, 0);

        // frame and key together: MOVE runs before HIT
        spawn(8'h43, 10'd5, 3'd0);
        spawn(8'h43, 10'd6, 3'd3);
        frame_tick = 1'b1;
        key_code   = 8'h43;
        key_valid  = 1'b1;
        tick();
        frame_tick = 1'b0;
        key_valid  = 1'b0;
        repeat (17) tick();
        chk("both_early", hit_pulse, 0);
        tick();
        chk("both_hit", hit_pulse, 1);
        chk("both_mask", active_mask, 8'h01);
        chk("both_score", score, 1);

        // reset in the middle of a MOVE sweep
        spawn(8'h44, 10'd7, 3'd2);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_mask", active_mask, 0);
        chk("abort_score", score, 0);
        chk("abort_cnts", {miss_count, gameover}, 0);
        chk("abort_pulses", {hit_pulse, wrong_pulse, miss_pulse}, 0);
        chk("abort_q", {q_active, q_row}, 0);
        chk("abort_ready", spawn_ready, 1);
        spawn(8'h45, 10'd8, 3'd2);
        frame_step();
        query(3'd0);
        chk("post_abort_row", q_row, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
